// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding for the bit-serial adder controller
package serial_adder_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell shared across all bit positions
module full_adder (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic s,
  output logic Cout
);
  assign s    = a ^ b ^ Cin;
  assign Cout = (a & b) | (Cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one shared full adder stepped LSB-first over WIDTH cycles
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s, fa_co, last, accept;
  full_adder u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .Cin (c_q),
    .s   (fa_s),
    .Cout(fa_co)
  );
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  assign accept = start_valid & start_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_valid) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  if (done_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    start_ready = state_q == S_IDLE;
    done_valid  = state_q == S_DONE;
    busy        = state_q != S_IDLE;
    sum         = s_q;
    cout        = c_q;
  end
  // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= op_a;
      b_q   <= op_b;
      c_q   <= cin;
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      s_q   <= WIDTH'({fa_s, s_q} >> 1);
      c_q   <= fa_co;
      cnt_q <= last ? cnt_q : cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for the bit-serial adder controller
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] op_a = '0, op_b = '0;
  logic       cin = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic       busy;
  typedef struct {
    logic [8:0] res;
    int         acc;
  } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, rdy_mode = 0;
  logic prev_dv = 1'b0;
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .cin        (cin),
    .sum        (sum),
    .cout       (cout),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    done_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_dv = 1'b0;
    end else begin
      if (done_valid && !prev_dv) begin
        n_chk++;
        if (sb.size() == 0 || cyc != sb[0].acc + 8) begin
          n_fail++;
          $display("FAIL latency: done_valid at cycle %0d, required %0d", cyc,
                   sb.size() == 0 ? -1 : sb[0].acc + 8);
        end
      end
      if (done_valid && done_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL result: unexpected result %h, none outstanding", {cout, sum});
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({cout, sum} !== e.res) begin
            n_fail++;
            $display("FAIL result: got %h required %h", {cout, sum}, e.res);
          end
        end
      end
      if (start_valid && start_ready)
        sb.push_back('{res: {1'b0, op_a} + {1'b0, op_b} + {8'b0, cin}, acc: cyc + 1});
      prev_dv = done_valid;
    end
  end
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n = 0;
    @(posedge clk);
    #1;
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    cin  = c;
    forever begin
      @(negedge clk);
      if (start_ready) break;
      if (++n > 200) begin
        chk("accept_timeout", 16'd0, 16'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    cin  = 1'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (start_ready) break;
      if (++n > 300) begin
        chk("idle_timeout", 16'd0, 16'd1);
        break;
      end
    end
  endtask
  task automatic wait_done();
    int n = 0;
    forever begin
      @(negedge clk);
      if (done_valid) break;
      if (++n > 50) begin
        chk("done_timeout", 16'd0, 16'd1);
        break;
      end
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, 16'(start_ready), 16'd1);
    chk({tag, "_done_valid"}, 16'(done_valid), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_sum"}, 16'(sum), 16'd0);
    chk({tag, "_cout"}, 16'(cout), 16'd0);
  endtask
  initial begin
    #2;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(8'h00, 8'h00, 1'b0);
    wait_idle();
    issue(8'hFF, 8'h01, 1'b0);
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b1);
    wait_idle();
    issue(8'h0F, 8'hF1, 1'b1);
    wait_idle();
    // Result 0xFF+0x01 held under backpressure while new starts are offered
    rdy_mode = 2;
    issue(8'hFF, 8'h01, 1'b0);
    wait_done();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      start_valid = 1'(i % 2);
      op_a = 8'h33;
      op_b = 8'h44;
      cin  = 1'b1;
      @(negedge clk);
      chk("hold_dv", 16'(done_valid), 16'd1);
      chk("hold_res", 16'({cout, sum}), 16'h100);
      chk("hold_start_ready", 16'(start_ready), 16'd0);
    end
    start_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();
    issue(8'hA7, 8'h5C, 1'b0);
    wait_idle();
    // Abort during the fourth RUN cycle, then confirm a clean restart
    issue(8'h5A, 8'hA5, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    chk("run_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    chk("abort_no_result", 16'(done_valid), 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(8'h12, 8'h34, 1'b0);
    wait_idle();
    rdy_mode = 1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(8'($urandom), 8'($urandom), 1'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
